tiny_nn_fp_add_arb: RTL and testbench

- Shares one external fixed-latency bfloat-style FP adder (fp_t: 1 sign, 8 exp, 7 mant = 16 bits) between NumReq requesters, such as neuron accumulators.
- Arbitrates round-robin and tracks requester ID through the adder latency, then routes each result back to its owner.
- Operands that are NaN under the codebase NaN rules skip the adder and return FPStdNaN with identical latency.
- Sits between the neuron/layer sequencers and the adder datapath.

---
 rtl/tiny_nn_fp_add_arb.sv | 148 ++++++++++++++
 tb/tb_tiny_nn_fp_add_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_nn_fp_add_arb.sv
// Round-robin sharing of one fixed-latency bfloat adder among NumReq requesters.
// Tracks requester ID through the adder latency; NaN operands bypass the adder.
module tiny_nn_fp_add_arb #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddLatency     = 3,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq*16-1:0]   req_a_i,
  input  logic [NumReq*16-1:0]   req_b_i,
  output logic [NumReq-1:0]      resp_valid_o,
  output logic [15:0]            resp_result_o,
  output logic                   add_valid_o,
  output logic [15:0]            add_a_o,
  output logic [15:0]            add_b_o,
  input  logic [15:0]            add_result_i,
  output logic                   busy_o
);

  localparam int unsigned IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [15:0] FPZero   = 16'h0000;
  localparam logic [15:0] FPStdNaN = 16'hFFFF;

  // No denormals, and negative zero is treated as NaN.
  function automatic logic is_nan(input logic [15:0] x);
    logic [7:0] e;
    logic [6:0] m;
    e = x[14:7];
    m = x[6:0];
    return ((e == 8'h00) && ((m != 7'd0) || x[15])) || ((e == 8'hFF) && (m != 7'd0));
  endfunction

  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q [NumReq];
  logic [CntW-1:0]       cnt_d [NumReq];
  logic [AddLatency-1:0] st_valid_q, st_valid_d;
  logic [AddLatency-1:0] st_nan_q, st_nan_d;
  logic [IdW-1:0]        st_id_q [AddLatency];
  logic [IdW-1:0]        st_id_d [AddLatency];
  logic [NumReq-1:0]     resp_valid_q, resp_valid_d;
  logic [15:0]           resp_result_q, resp_result_d;

  logic [NumReq-1:0] eligible, gnt;
  logic [IdW-1:0]    gnt_id;
  logic              gnt_any, gnt_nan;
  logic [15:0]       gnt_a, gnt_b;
  int unsigned       idx;

  // Grants are suppressed while reset is held so outputs match their reset values.
  always_comb begin
    eligible = '0;
    gnt      = '0;
    gnt_id   = '0;
    gnt_any  = 1'b0;
    gnt_a    = FPZero;
    gnt_b    = FPZero;
    idx      = 0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = rst_ni && req_valid_i[i] && (32'(cnt_q[i]) < MaxOutstanding);
    end
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!gnt_any && eligible[IdW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = IdW'(idx);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_any && (gnt_id == IdW'(i))) begin
        gnt[i] = 1'b1;
        gnt_a  = req_a_i[16*i +: 16];
        gnt_b  = req_b_i[16*i +: 16];
      end
    end
    gnt_nan = is_nan(gnt_a) || is_nan(gnt_b);
  end

  assign req_ready_o = gnt;
  assign add_valid_o = gnt_any && !gnt_nan;
  assign add_a_o     = add_valid_o ? gnt_a : FPZero;
  assign add_b_o     = add_valid_o ? gnt_b : FPZero;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + IdW'(1);
    end

    st_valid_d[0] = gnt_any;
    st_nan_d[0]   = gnt_nan;
    st_id_d[0]    = gnt_id;
    for (int s = 1; s < AddLatency; s++) begin
      st_valid_d[s] = st_valid_q[s-1];
      st_nan_d[s]   = st_nan_q[s-1];
      st_id_d[s]    = st_id_q[s-1];
    end

    // The last stage lines up with add_result_i; NaN entries never look at it.
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    if (st_valid_q[AddLatency-1]) begin
      resp_valid_d  = NumReq'(1) << st_id_q[AddLatency-1];
      resp_result_d = st_nan_q[AddLatency-1] ? FPStdNaN : add_result_i;
    end

    for (int i = 0; i < NumReq; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !resp_valid_q[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (!gnt[i] && resp_valid_q[i]) begin
        cnt_d[i] = cnt_q[i] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q         <= '0;
      st_valid_q    <= '0;
      st_nan_q      <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= FPZero;
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
      for (int s = 0; s < AddLatency; s++) st_id_q[s] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        assert (!(resp_valid_q[i] && (cnt_q[i] == '0)));
      end
      ptr_q         <= ptr_d;
      st_valid_q    <= st_valid_d;
      st_nan_q      <= st_nan_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= cnt_d[i];
      for (int s = 0; s < AddLatency; s++) st_id_q[s] <= st_id_d[s];
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = resp_result_q;
  assign busy_o        = (|st_valid_q) || (|resp_valid_q);

endmodule

// File: tb/tb_tiny_nn_fp_add_arb.sv
// Directed bench for tiny_nn_fp_add_arb with a 3-cycle table-driven adder model.
module tb_tiny_nn_fp_add_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_valid_i, req_ready_o, resp_valid_o;
  logic [63:0] req_a_i, req_b_i;
  logic [15:0] resp_result_o, add_a_o, add_b_o, add_result_i;
  logic        add_valid_o, busy_o;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [15:0] RrA   [4] = '{16'h3F80, 16'h3F80, 16'h4000, 16'h4000};
  localparam logic [15:0] RrB   [4] = '{16'h4000, 16'h3F80, 16'h4000, 16'h4040};
  localparam logic [15:0] RrSum [4] = '{16'h4040, 16'h4000, 16'h4080, 16'h40A0};

  always #5 clk_i = ~clk_i;

  tiny_nn_fp_add_arb #(
    .NumReq         (4),
    .AddLatency     (3),
    .MaxOutstanding (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .resp_valid_o  (resp_valid_o),
    .resp_result_o (resp_result_o),
    .add_valid_o   (add_valid_o),
    .add_a_o       (add_a_o),
    .add_b_o       (add_b_o),
    .add_result_i  (add_result_i),
    .busy_o        (busy_o)
  );

  // Hand-computed bfloat16 sums for the operand pairs used below.
  function automatic logic [15:0] fp_sum(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3F80_4000: return 16'h4040;
      32'h3F80_3F80: return 16'h4000;
      32'h4000_4000: return 16'h4080;
      32'h4000_4040: return 16'h40A0;
      32'h7F80_3F80: return 16'h7F80;
      default:       return 16'hDEAD;
    endcase
  endfunction

  logic [15:0] add_pipe [3];
  always @(posedge clk_i) begin
    add_pipe[0] <= add_valid_o ? fp_sum(add_a_o, add_b_o) : 16'h0BAD;
    add_pipe[1] <= add_pipe[0];
    add_pipe[2] <= add_pipe[1];
  end
  assign add_result_i = add_pipe[2];

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
    req_a_i[16*id +: 16] = a;
    req_b_i[16*id +: 16] = b;
  endtask

  // One isolated op: checks grant/issue at T, silence T+1..T+3, response at T+4.
  task automatic single_op(input string tag, input int id, input logic [15:0] a,
                           input logic [15:0] b, input logic exp_issue,
                           input logic [15:0] exp_res);
    adv();
    req_valid_i = 4'b0001 << id;
    set_op(id, a, b);
    #3;
    chk({tag, "_ready"}, req_ready_o, 4'b0001 << id);
    chk({tag, "_issue"}, add_valid_o, exp_issue);
    chk({tag, "_add_a"}, add_a_o, exp_issue ? a : 16'h0000);
    adv();
    req_valid_i = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      #3;
      chk({tag, "_quiet"}, resp_valid_o, 4'b0000);
      chk({tag, "_busy"}, busy_o, 1'b1);
      adv();
    end
    #3;
    chk({tag, "_resp"}, resp_valid_o, 4'b0001 << id);
    chk({tag, "_result"}, resp_result_o, exp_res);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    #3;
    chk("rst_ready", req_ready_o, 4'b0000);
    chk("rst_resp_valid", resp_valid_o, 4'b0000);
    chk("rst_resp_result", resp_result_o, 16'h0000);
    chk("rst_add_valid", add_valid_o, 1'b0);
    chk("rst_add_a", add_a_o, 16'h0000);
    chk("rst_add_b", add_b_o, 16'h0000);
    chk("rst_busy", busy_o, 1'b0);
    adv();
    adv();
    rst_ni = 1'b1;

    // Round-robin with all four requesters valid for 8 cycles.
    for (int i = 0; i < 4; i++) set_op(i, RrA[i], RrB[i]);
    for (int k = 0; k < 12; k++) begin
      adv();
      req_valid_i = (k < 8) ? 4'hF : 4'h0;
      #3;
      chk("rr_ready", req_ready_o, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
      if (k < 8) chk("rr_add_a", add_a_o, RrA[k % 4]);
      if (k >= 4) begin
        chk("rr_resp", resp_valid_o, 4'b0001 << ((k - 4) % 4));
        chk("rr_result", resp_result_o, RrSum[(k - 4) % 4]);
      end else begin
        chk("rr_resp_idle", resp_valid_o, 4'b0000);
      end
    end

    single_op("single", 0, 16'h3F80, 16'h4000, 1'b1, 16'h4040);
    single_op("nan_denorm", 1, 16'h0001, 16'h3F80, 1'b0, 16'hFFFF);
    single_op("nan_negzero", 1, 16'h8000, 16'h3F80, 1'b0, 16'hFFFF);
    single_op("nan_qnan", 1, 16'h7FC1, 16'h3F80, 1'b0, 16'hFFFF);
    single_op("inf_ok", 1, 16'h7F80, 16'h3F80, 1'b1, 16'h7F80);

    // Outstanding limit on requester 2.
    set_op(2, 16'h3F80, 16'h3F80);
    for (int k = 0; k < 11; k++) begin
      adv();
      req_valid_i = (k < 8) ? 4'b0100 : 4'b0000;
      #3;
      chk("lim_ready", req_ready_o,
          (k <= 1 || k == 5 || k == 6) ? 4'b0100 : 4'b0000);
      chk("lim_resp", resp_valid_o,
          (k == 4 || k == 5 || k == 9 || k == 10) ? 4'b0100 : 4'b0000);
    end

    // Mixed ordering: normal op on 0, then NaN op on 3.
    adv();
    req_valid_i = 4'b0001;
    set_op(0, 16'h3F80, 16'h3F80);
    #3;
    chk("mix_ready0", req_ready_o, 4'b0001);
    adv();
    req_valid_i = 4'b1000;
    set_op(3, 16'h7FC1, 16'h3F80);
    #3;
    chk("mix_ready3", req_ready_o, 4'b1000);
    chk("mix_issue3", add_valid_o, 1'b0);
    adv();
    req_valid_i = 4'b0000;
    adv();
    #3;
    chk("mix_quiet", resp_valid_o, 4'b0000);
    adv();
    #3;
    chk("mix_resp0", resp_valid_o, 4'b0001);
    chk("mix_result0", resp_result_o, 16'h4000);
    adv();
    #3;
    chk("mix_resp3", resp_valid_o, 4'b1000);
    chk("mix_result3", resp_result_o, 16'hFFFF);
    adv();
    #3;
    chk("mix_done", resp_valid_o, 4'b0000);

    // Reset with two ops in flight.
    adv();
    req_valid_i = 4'b0001;
    set_op(0, 16'h3F80, 16'h4000);
    adv();
    req_valid_i = 4'b0010;
    set_op(1, 16'h3F80, 16'h3F80);
    adv();
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready_o, 4'b0000);
    chk("mid_rst_resp", resp_valid_o, 4'b0000);
    chk("mid_rst_result", resp_result_o, 16'h0000);
    chk("mid_rst_add_valid", add_valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    req_valid_i = 4'b0000;
    adv();
    adv();
    rst_ni = 1'b1;
    for (int k = 0; k < 6; k++) begin
      adv();
      #3;
      chk("post_rst_quiet", resp_valid_o, 4'b0000);
      chk("post_rst_busy", busy_o, 1'b0);
    end
    for (int i = 0; i < 4; i++) set_op(i, 16'h3F80, 16'h4000);
    adv();
    req_valid_i = 4'hF;
    #3;
    chk("post_rst_first_grant", req_ready_o, 4'b0001);
    adv();
    req_valid_i = 4'h0;
    adv();
    adv();
    adv();
    #3;
    chk("post_rst_resp", resp_valid_o, 4'b0001);
    chk("post_rst_result", resp_result_o, 16'h4040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
